// File: rtl/bridge_pkg.sv
// Shared types, AXI encodings and strobe helper for the CPU-to-AXI3 bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW_W = 2'd1,
    W_B    = 2'd2
  } w_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_UC   = 4'b0000;
  localparam logic [3:0] CACHE_WB   = 4'b1111;

  // Byte lanes touched by a single-beat store; wdata itself is never shifted.
  function automatic logic [3:0] size_addr_to_wstrb(input logic [1:0] size,
                                                    input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr;
      2'd1:    strb = addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  function automatic logic [3:0] cache_bits(input logic uncached);
    return uncached ? CACHE_UC : CACHE_WB;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's sram-like inst/data ports onto one AXI3 master.
// One read and one write may be outstanding; data reads win over inst reads.
//
// Read FSM
//   state  | meaning
//   R_IDLE | no read in flight, accepts data (priority) or inst read
//   R_AR   | arvalid held with latched address until arready
//   R_R    | rready high, waiting for the beat whose rid matches r_owner
// Write FSM
//   state  | meaning
//   W_IDLE | no write in flight, accepts a data write
//   W_AW_W | AW and W raised together, each dropped after its own handshake
//   W_B    | bready high, bvalid completes the store with data_data_ok
module cpu_axi_bridge
  import bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic        inst_uncached,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_uncached,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;
  logic     r_owner;
  logic     aw_done, w_done;
  logic     data_rd_acc, inst_rd_acc, data_wr_acc;
  logic     r_done, aw_hs, w_hs;

  // Instruction fetches never write; these inputs exist only for port symmetry.
  logic unused_inst;
  assign unused_inst = &{1'b0, inst_wr, inst_wdata};

  assign data_rd_acc = data_req && !data_wr && (r_state == R_IDLE) && (w_state == W_IDLE);
  assign inst_rd_acc = inst_req && (r_state == R_IDLE) && !data_rd_acc;
  // A store may not pass a data load still in flight (same-address ordering).
  assign data_wr_acc = data_req && data_wr && (w_state == W_IDLE) &&
                       !((r_state != R_IDLE) && r_owner);
  assign r_done = (r_state == R_R) && rvalid && rlast &&
                  (rid == (r_owner ? ID_DATA : ID_INST));
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;

  assign arid       = r_owner ? ID_DATA : ID_INST;
  assign arlen      = 4'd0;
  assign arburst    = BURST_INCR;
  assign arlock     = 2'd0;
  assign arprot     = 3'd0;
  assign awid       = ID_DATA;
  assign awlen      = 4'd0;
  assign awburst    = BURST_INCR;
  assign awlock     = 2'd0;
  assign awprot     = 3'd0;
  assign wid        = ID_DATA;
  assign wlast      = 1'b1;
  assign inst_rdata = rdata;
  assign data_rdata = rdata;

  // State registers for both channel FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (data_rd_acc || inst_rd_acc) r_state_nxt = R_AR;
      R_AR:    if (arready) r_state_nxt = R_R;
      R_R:     if (r_done) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Write FSM next state; AW and W may complete in either order.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (data_wr_acc) w_state_nxt = W_AW_W;
      W_AW_W:  if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_nxt = W_B;
      W_B:     if (bvalid) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Handshake and completion outputs decoded from state.
  always_comb begin
    arvalid      = (r_state == R_AR);
    rready       = (r_state == R_R);
    awvalid      = (w_state == W_AW_W) && !aw_done;
    wvalid       = (w_state == W_AW_W) && !w_done;
    bready       = (w_state == W_B);
    inst_addr_ok = inst_rd_acc;
    data_addr_ok = data_rd_acc || data_wr_acc;
    inst_data_ok = r_done && !r_owner;
    data_data_ok = (r_done && r_owner) || ((w_state == W_B) && bvalid);
  end

  // Latch the accepted read request; data wins when both are accepted candidates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
      arcache <= 4'd0;
    end else if (data_rd_acc) begin
      r_owner <= 1'b1;
      araddr  <= data_addr;
      arsize  <= {1'b0, data_size};
      arcache <= cache_bits(data_uncached);
    end else if (inst_rd_acc) begin
      r_owner <= 1'b0;
      araddr  <= inst_addr;
      arsize  <= {1'b0, inst_size};
      arcache <= cache_bits(inst_uncached);
    end
  end

  // Latch the accepted write and track which of AW/W has already handshaken.
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr  <= 32'd0;
      awsize  <= 3'd0;
      awcache <= 4'd0;
      wdata   <= 32'd0;
      wstrb   <= 4'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (data_wr_acc) begin
      awaddr  <= data_addr;
      awsize  <= {1'b0, data_size};
      awcache <= cache_bits(data_uncached);
      wdata   <= data_wdata;
      wstrb   <= size_addr_to_wstrb(data_size, data_addr[1:0]);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (w_state == W_AW_W) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Scoreboarded bench for cpu_axi_bridge: a delay-programmable AXI3 slave,
// sram-like master tasks, and a negedge monitor that pops expectations.
module tb_cpu_axi_bridge;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 0, inst_wr = 0, inst_uncached = 0;
  logic [1:0]  inst_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0, data_uncached = 0;
  logic [1:0]  data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;
  logic        arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [3:0]  rid = 0;
  logic [31:0] rdata = 0;

  cpu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_uncached(inst_uncached), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_uncached(data_uncached), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard structures
  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  cache;
  } ax_t;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_t;
  typedef struct {
    bit          wr;
    logic [31:0] data;
  } dok_t;

  ax_t         ar_q[$];
  ax_t         aw_q[$];
  w_t          w_q[$];
  logic [31:0] inst_q[$];
  dok_t        data_q[$];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_BFC0;
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      2'd2: s = 4'b1111;
      2'd1: s = a[1] ? 4'b1100 : 4'b0011;
      default: s[a] = 1'b1;
    endcase
    return s;
  endfunction

  // Slave model: decisions from values sampled at negedge, outputs driven 1 after posedge
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  logic [3:0]  r_id_q;
  logic [31:0] r_addr_q;
  bit s_rst, s_ar, s_arv, s_r, s_aw, s_awv, s_w, s_wv, s_b;
  logic [3:0]  s_arid;
  logic [31:0] s_araddr;

  always begin
    @(negedge clk);
    s_rst = rst;
    s_ar = arvalid && arready;  s_arv = arvalid;
    s_r  = rvalid && rready;
    s_aw = awvalid && awready;  s_awv = awvalid;
    s_w  = wvalid && wready;    s_wv = wvalid;
    s_b  = bvalid && bready;
    s_arid = arid;  s_araddr = araddr;
    @(posedge clk);
    #1;
    if (s_rst) begin
      arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    end else begin
      if (s_ar) begin
        r_pend = 1; r_cnt = 0; r_id_q = s_arid; r_addr_q = s_araddr;
        ar_cnt = 0; arready = (ar_delay == 0);
      end else if (s_arv) begin
        ar_cnt++;
        if (ar_cnt >= ar_delay) arready = 1;
      end else arready = (ar_delay == 0);

      if (s_r) begin
        rvalid = 0; rlast = 0; r_pend = 0;
      end else if (r_pend && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid = 1; rlast = 1; rid = r_id_q; rdata = mem_val(r_addr_q);
        end else r_cnt++;
      end

      if (s_aw) begin
        aw_got = 1; aw_cnt = 0; awready = (aw_delay == 0);
      end else if (s_awv) begin
        aw_cnt++;
        if (aw_cnt >= aw_delay) awready = 1;
      end else awready = (aw_delay == 0);

      if (s_w) begin
        w_got = 1; w_cnt = 0; wready = (w_delay == 0);
      end else if (s_wv) begin
        w_cnt++;
        if (w_cnt >= w_delay) wready = 1;
      end else wready = (w_delay == 0);

      if (s_b) begin
        bvalid = 0; b_pend = 0;
      end else if (aw_got && w_got && !b_pend) begin
        b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
      end
      if (b_pend && !bvalid && !s_b) begin
        if (b_cnt >= b_delay) bvalid = 1;
        else b_cnt++;
      end
    end
  end

  // Monitor: checks every AXI beat and ok pulse against the scoreboard queues
  int   ar_hold_n = 0, last_ar_hold = 0;
  int   aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  int   last_b_cyc = -1, last_dok_cyc = -1;
  ax_t  m_ax;
  w_t   m_w;
  dok_t m_d;

  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid) begin
        ar_hold_n++;
        if (ar_q.size() == 0) chk("ar_spurious", {31'b0, arvalid}, 0);
        else begin
          m_ax = ar_q[0];
          chk("araddr", araddr, m_ax.addr);
          chk("ar_id_size_cache", {arid, arsize, arcache}, {m_ax.id, m_ax.size, m_ax.cache});
          if (arready) begin
            last_ar_hold = ar_hold_n; ar_hold_n = 0;
            void'(ar_q.pop_front());
          end
        end
      end
      if (awvalid) begin
        if (aw_q.size() == 0) chk("aw_spurious", {31'b0, awvalid}, 0);
        else begin
          m_ax = aw_q[0];
          chk("awaddr", awaddr, m_ax.addr);
          chk("aw_id_size_cache", {awid, awsize, awcache}, {m_ax.id, m_ax.size, m_ax.cache});
          if (awready) begin aw_hs_n++; void'(aw_q.pop_front()); end
        end
      end
      if (wvalid) begin
        if (w_q.size() == 0) chk("w_spurious", {31'b0, wvalid}, 0);
        else begin
          m_w = w_q[0];
          chk("wdata", wdata, m_w.data);
          chk("wstrb_wlast_wid", {wstrb, wlast, wid}, {m_w.strb, 1'b1, 4'd1});
          if (wready) begin w_hs_n++; void'(w_q.pop_front()); end
        end
      end
      if (bvalid && bready) begin b_hs_n++; last_b_cyc = cyc; end
      if (inst_data_ok) begin
        if (inst_q.size() == 0) chk("inst_ok_spurious", {31'b0, inst_data_ok}, 0);
        else chk("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
        if (data_q.size() == 0) chk("data_ok_spurious", {31'b0, data_data_ok}, 0);
        else begin
          m_d = data_q.pop_front();
          if (m_d.wr) chk("wr_ok_on_b", {31'b0, bvalid && bready}, 1);
          else chk("data_rdata", data_rdata, m_d.data);
          last_dok_cyc = cyc;
        end
      end
    end
  end

  // Master tasks: hold request until addr_ok, then push expectations
  task automatic inst_read(input logic [31:0] addr, input logic uc, output int acc, output int waited);
    int n;
    ax_t e;
    @(posedge clk); #1;
    inst_req = 1; inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'd2;
    inst_addr = addr; inst_uncached = uc; inst_wdata = $urandom;
    n = 0;
    forever begin
      @(negedge clk);
      if (inst_addr_ok || n >= TMO) break;
      n++;
    end
    if (!inst_addr_ok) chk("inst_aok_timeout", {31'b0, inst_addr_ok}, 1);
    e.id = 4'd0; e.addr = addr; e.size = 3'd2; e.cache = uc ? 4'b0000 : 4'b1111;
    ar_q.push_back(e);
    inst_q.push_back(mem_val(addr));
    acc = cyc; waited = n;
    @(posedge clk); #1;
    inst_req = 0;
  endtask

  task automatic data_access(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wd, input logic uc, output int acc, output int waited);
    int   n;
    ax_t  e;
    w_t   ew;
    dok_t ed;
    @(posedge clk); #1;
    data_req = 1; data_wr = wr; data_size = size; data_addr = addr;
    data_wdata = wd; data_uncached = uc;
    n = 0;
    forever begin
      @(negedge clk);
      if (data_addr_ok || n >= TMO) break;
      n++;
    end
    if (!data_addr_ok) chk("data_aok_timeout", {31'b0, data_addr_ok}, 1);
    e.id = 4'd1; e.addr = addr; e.size = {1'b0, size}; e.cache = uc ? 4'b0000 : 4'b1111;
    ed.wr = wr;
    if (wr) begin
      aw_q.push_back(e);
      ew.data = wd; ew.strb = exp_strb(size, addr[1:0]);
      w_q.push_back(ew);
      ed.data = 32'd0;
    end else begin
      ar_q.push_back(e);
      ed.data = mem_val(addr);
    end
    data_q.push_back(ed);
    acc = cyc; waited = n;
    @(posedge clk); #1;
    data_req = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n, left;
    n = 0;
    left = ar_q.size() + aw_q.size() + w_q.size() + inst_q.size() + data_q.size();
    while (left != 0 && n < TMO) begin
      @(negedge clk);
      n++;
      left = ar_q.size() + aw_q.size() + w_q.size() + inst_q.size() + data_q.size();
    end
    if (left != 0) chk(tag, left, 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int i_acc, i_wait, d_acc, d_wait, a0, w0, aw0, wv0, b0, n;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready},  5'b0);
    chk("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 4'b0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata_wstrb", {wdata[27:0], wstrb}, 0);
    @(posedge clk); #1;
    rst = 0;

    // Inst read with arready delayed two cycles
    ar_delay = 2; r_delay = 1;
    inst_read(32'hBFC0_0000, 0, i_acc, i_wait);
    chk("inst_aok_lat", i_wait, 0);
    wait_idle("t1_idle");
    chk("ar_hold", last_ar_hold, 3);

    // Collision: data read wins, inst waits until after data_data_ok
    ar_delay = 0; r_delay = 2;
    fork
      inst_read(32'hBFC0_0004, 0, i_acc, i_wait);
      data_access(0, 32'h8000_1000, 2'd2, 32'h0, 0, d_acc, d_wait);
    join
    chk("collide_data_lat", d_wait, 0);
    chk("collide_inst_later", {31'b0, i_acc > d_acc}, 1);
    chk("inst_after_dok", i_acc, last_dok_cyc + 1);
    wait_idle("t2_idle");

    // Store byte at offset 3
    aw0 = aw_hs_n; b0 = b_hs_n;
    data_access(1, 32'h8000_0003, 2'd0, 32'hAB00_0000, 0, d_acc, d_wait);
    wait_idle("t3_idle");
    chk("t3_b_once", b_hs_n - b0, 1);
    chk("t3_aw_once", aw_hs_n - aw0, 1);

    // AW before W, then W before AW
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 0 : 3;
      w_delay  = (k == 0) ? 3 : 0;
      b_delay  = 1;
      aw0 = aw_hs_n; wv0 = w_hs_n; b0 = b_hs_n;
      data_access(1, 32'h8000_0040 + k * 4, 2'd2, 32'h5A5A_0000 + k, 0, d_acc, d_wait);
      wait_idle("t4_idle");
      chk("t4_aw_once", aw_hs_n - aw0, 1);
      chk("t4_w_once", w_hs_n - wv0, 1);
      chk("t4_b_once", b_hs_n - b0, 1);
    end

    // Data read blocked by outstanding write; concurrent inst read proceeds
    aw_delay = 2; w_delay = 2; b_delay = 3; ar_delay = 0; r_delay = 0;
    fork
      data_access(1, 32'h8000_0100, 2'd2, 32'h1234_5678, 0, a0, w0);
      begin
        repeat (2) @(posedge clk);
        fork
          data_access(0, 32'h8000_0200, 2'd2, 32'h0, 0, d_acc, d_wait);
          inst_read(32'hBFC0_0010, 0, i_acc, i_wait);
        join
      end
    join
    chk("rd_after_b", d_acc, last_b_cyc + 1);
    chk("inst_overlap_lat", i_wait, 0);
    wait_idle("t5_idle");

    // Sweep of store sizes/offsets with random delays and overlapping inst reads
    for (int s = 0; s < 3; s++) begin
      for (int a = 0; a < 4; a++) begin
        ar_delay = $urandom_range(0, 2); r_delay = $urandom_range(0, 2);
        aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 2);
        b_delay = $urandom_range(0, 2);
        fork
          data_access(1, 32'h8000_2000 + 32'(s * 16 + a), 2'(s), $urandom, 1'(a & 1), a0, w0);
          inst_read(32'hBFC0_1000 + 32'(s * 64 + a * 4), 1'(s & 1), i_acc, i_wait);
        join
        data_access(0, 32'h8000_3000 + 32'(a * 4), 2'(s), $urandom, 1'(s & 1), d_acc, d_wait);
        wait_idle("sweep_idle");
      end
    end

    // Uncached data read, then reset while in R_R
    ar_delay = 0; r_delay = 8;
    data_access(0, 32'h8000_4000, 2'd2, 32'h0, 1, d_acc, d_wait);
    n = 0;
    while (!rready && n < TMO) begin @(negedge clk); n++; end
    chk("rr_reached", {31'b0, rready}, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    ar_q.delete(); aw_q.delete(); w_q.delete(); inst_q.delete(); data_q.delete();
    @(negedge clk);
    chk("post_rst_ar_r", {arvalid, rready}, 2'b00);
    chk("post_rst_oks", {inst_data_ok, data_data_ok, data_addr_ok}, 3'b000);
    repeat (12) @(negedge clk);
    chk("post_rst_no_dok", {data_data_ok, inst_data_ok, rready}, 3'b000);

    // Bridge still works after reset
    r_delay = 0;
    inst_read(32'hBFC0_0000, 0, i_acc, i_wait);
    chk("post_rst_inst_lat", i_wait, 0);
    wait_idle("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
